// File: rtl/ofifo_drain_ctrl_pkg.sv
// rtl/ofifo_drain_ctrl_pkg.sv - shared widths and FSM state encoding for the output-FIFO drain sequencer
package ofifo_drain_ctrl_pkg;

   localparam int COL     = 8;
   localparam int PSUM_BW = 16;
   localparam int ADDR_BW = 11;
   localparam int CNT_BW  = 11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/ofifo_drain_ctrl_psum_relu.sv
// rtl/ofifo_drain_ctrl_psum_relu.sv - combinational per-lane clamp of negative psums to zero
module psum_relu #(
   parameter int col     = 8,
   parameter int psum_bw = 16
) (
   input  logic [psum_bw*col-1:0] din,
   output logic [psum_bw*col-1:0] dout
);

   always_comb begin
      dout = din;
      for (int i = 0; i < col; i++) begin
         if (din[i*psum_bw + psum_bw - 1]) begin
            dout[i*psum_bw +: psum_bw] = '0;
         end
      end
   end

endmodule

// File: rtl/ofifo_drain_ctrl.sv
// rtl/ofifo_drain_ctrl.sv - drains output-FIFO psum vectors into the psum SRAM
// Optional lane ReLU on the write data when OFIFO_DRAIN_RELU_EN is defined.
module ofifo_drain_ctrl
   import ofifo_drain_ctrl_pkg::*;
#(
   parameter int col     = COL,
   parameter int psum_bw = PSUM_BW,
   parameter int addr_bw = ADDR_BW,
   parameter int cnt_bw  = CNT_BW
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [cnt_bw-1:0]        num_vec,
   input  logic [addr_bw-1:0]       base_addr,
   input  logic                     ofifo_valid,
   input  logic [psum_bw*col-1:0]   ofifo_out,
   output logic                     ofifo_rd,
   output logic                     sram_cen,
   output logic                     sram_wen,
   output logic [addr_bw-1:0]       sram_a,
   output logic [psum_bw*col-1:0]   sram_d,
   output logic                     busy,
   output logic                     done
);

   state_e               state_q, state_d;
   logic [cnt_bw-1:0]    num_q, num_d;
   logic [cnt_bw-1:0]    rd_cnt_q, rd_cnt_d;
   logic [cnt_bw-1:0]    wr_cnt_q, wr_cnt_d;
   logic [addr_bw-1:0]   base_q, base_d;
   logic [addr_bw-1:0]   sram_a_q, sram_a_d;
   logic                 ofifo_rd_q, ofifo_rd_d;
   logic                 rd_dly_q, rd_dly_d;
   logic                 sram_cen_q, sram_cen_d;
   logic                 sram_wen_q, sram_wen_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 accept;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // DRAIN exits once the final pop is issued; FLUSH exits while the final write is driven.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = (num_vec == '0) ? ST_DONE : ST_DRAIN;
         ST_DRAIN: if (rd_cnt_d == num_q) state_d = ST_FLUSH;
         ST_FLUSH: if (wr_cnt_d == num_q) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered, so each *_d looks one cycle ahead; rd_dly mirrors last cycle's pop.
   always_comb begin
      accept   = (state_q == ST_IDLE) && start;
      num_d    = num_q;
      base_d   = base_q;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      if (accept) begin
         num_d    = num_vec;
         base_d   = base_addr;
         rd_cnt_d = '0;
         wr_cnt_d = '0;
      end else begin
         if (ofifo_rd_q) rd_cnt_d = rd_cnt_q + cnt_bw'(1);
         if (rd_dly_q)   wr_cnt_d = wr_cnt_q + cnt_bw'(1);
      end
      rd_dly_d   = ofifo_rd_q;
      ofifo_rd_d = (state_d == ST_DRAIN) && ofifo_valid && !ofifo_rd_q && (rd_cnt_d < num_d);
      sram_cen_d = !ofifo_rd_q;
      sram_wen_d = !ofifo_rd_q;
      sram_a_d   = ofifo_rd_q ? (base_q + addr_bw'(wr_cnt_d)) : sram_a_q;
      busy_d     = (state_d == ST_DRAIN) || (state_d == ST_FLUSH);
      done_d     = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         num_q      <= '0;
         base_q     <= '0;
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
         ofifo_rd_q <= 1'b0;
         rd_dly_q   <= 1'b0;
         sram_cen_q <= 1'b1;
         sram_wen_q <= 1'b1;
         sram_a_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         num_q      <= num_d;
         base_q     <= base_d;
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         ofifo_rd_q <= ofifo_rd_d;
         rd_dly_q   <= rd_dly_d;
         sram_cen_q <= sram_cen_d;
         sram_wen_q <= sram_wen_d;
         sram_a_q   <= sram_a_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign ofifo_rd = ofifo_rd_q;
   assign sram_cen = sram_cen_q;
   assign sram_wen = sram_wen_q;
   assign sram_a   = sram_a_q;
   assign busy     = busy_q;
   assign done     = done_q;

`ifdef OFIFO_DRAIN_RELU_EN
   psum_relu #(
      .col     (col),
      .psum_bw (psum_bw)
   ) u_psum_relu (
      .din  (ofifo_out),
      .dout (sram_d)
   );
`else
   assign sram_d = ofifo_out;
`endif

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// tb/tb_ofifo_drain_ctrl.sv - directed self-checking bench for ofifo_drain_ctrl
module tb_ofifo_drain_ctrl;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [10:0]   num_vec;
   logic [10:0]   base_addr;
   logic          ofifo_valid;
   logic [127:0]  ofifo_out;
   logic          ofifo_rd;
   logic          sram_cen;
   logic          sram_wen;
   logic [10:0]   sram_a;
   logic [127:0]  sram_d;
   logic          busy;
   logic          done;

   int total = 0;
   int bad   = 0;

   int            pop_c[$];
   int            wr_c[$];
   int            wr_a[$];
   logic [127:0]  wr_d[$];
   int            done_c;
   int            viol;
   logic [63:0]   busy_hist;
   logic [127:0]  data[8];

   always #5 clk = ~clk;

   ofifo_drain_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .num_vec     (num_vec),
      .base_addr   (base_addr),
      .ofifo_valid (ofifo_valid),
      .ofifo_out   (ofifo_out),
      .ofifo_rd    (ofifo_rd),
      .sram_cen    (sram_cen),
      .sram_wen    (sram_wen),
      .sram_a      (sram_a),
      .sram_d      (sram_d),
      .busy        (busy),
      .done        (done)
   );

   task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic fill_data(input int s);
      for (int k = 0; k < 8; k++) begin
         data[k] = {8{16'(k * 257 + s)}};
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk_eq({tag, "_rd"},   ofifo_rd, 0);
      chk_eq({tag, "_cen"},  sram_cen, 1);
      chk_eq({tag, "_wen"},  sram_wen, 1);
      chk_eq({tag, "_a"},    sram_a,   0);
      chk_eq({tag, "_busy"}, busy,     0);
      chk_eq({tag, "_done"}, done,     0);
   endtask

   // Cycle 0 carries start; cycle c is sampled at the falling edge after rising edge c-1.
   task automatic run_job(input int nv, input int ba, input logic [63:0] low_mask,
                          input int ncyc, input int restart_c, input int rst_c);
      int  widx;
      logic prev_rd;
      pop_c.delete(); wr_c.delete(); wr_a.delete(); wr_d.delete();
      done_c = -1; viol = 0; busy_hist = '0; widx = 0; prev_rd = 1'b0;
      @(negedge clk);
      start = 1'b1; num_vec = 11'(nv); base_addr = 11'(ba);
      ofifo_valid = !low_mask[0]; ofifo_out = data[0];
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         start = (c == restart_c);
         if (c == restart_c) begin
            num_vec = 11'd2; base_addr = 11'd500;
         end
         busy_hist[c] = busy;
         if (ofifo_rd) begin
            pop_c.push_back(c);
            if (low_mask[c] || prev_rd) viol++;
         end
         prev_rd = ofifo_rd;
         if (sram_cen !== sram_wen) viol++;
         if (sram_cen == 1'b0) begin
            wr_c.push_back(c);
            wr_a.push_back(int'(sram_a));
            wr_d.push_back(sram_d);
            widx++;
            if (widx < 8) ofifo_out = data[widx];
         end
         if (done && done_c < 0) done_c = c;
         ofifo_valid = !low_mask[c];
         if (c == rst_c) begin
            reset = 1'b0;
            #1;
            chk_reset_outs("midreset");
            @(negedge clk);
            reset = 1'b1;
            break;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      logic [127:0] relu_exp;
      reset = 1'b0; start = 1'b0; num_vec = '0; base_addr = '0;
      ofifo_valid = 1'b0; ofifo_out = '0;
      fill_data(3);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outs("por");
      reset = 1'b1;
      @(negedge clk);

      // basic 4-vector job, FIFO always ready
      run_job(4, 10, 64'h0, 12, -1, -1);
      chk_eq("t1_npop", pop_c.size(), 4);
      chk_eq("t1_nwr", wr_c.size(), 4);
      if (pop_c.size() == 4 && wr_c.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            chk_eq($sformatf("t1_pop%0d", k), pop_c[k], 1 + 2 * k);
            chk_eq($sformatf("t1_wrc%0d", k), wr_c[k], 2 + 2 * k);
            chk_eq($sformatf("t1_adr%0d", k), wr_a[k], 10 + k);
            chk_eq($sformatf("t1_dat%0d", k), wr_d[k], data[k]);
         end
      end
      chk_eq("t1_done", done_c, 9);
      chk_eq("t1_busy8", busy_hist[8], 1);
      chk_eq("t1_busy9", busy_hist[9], 0);
      chk_eq("t1_rules", viol, 0);

      // FIFO stall in cycles 2..5
      fill_data(17);
      run_job(3, 40, 64'h3C, 20, -1, -1);
      chk_eq("t2_npop", pop_c.size(), 3);
      chk_eq("t2_nwr", wr_c.size(), 3);
      if (wr_c.size() == 3) begin
         for (int k = 0; k < 3; k++) begin
            chk_eq($sformatf("t2_adr%0d", k), wr_a[k], 40 + k);
            chk_eq($sformatf("t2_dat%0d", k), wr_d[k], data[k]);
         end
      end
      chk_eq("t2_done_seen", done_c > 0, 1);
      chk_eq("t2_rules", viol, 0);

      // address wrap at the top of the SRAM
      run_job(4, 2046, 64'h0, 12, -1, -1);
      chk_eq("t3_nwr", wr_c.size(), 4);
      if (wr_c.size() == 4) begin
         chk_eq("t3_adr0", wr_a[0], 2046);
         chk_eq("t3_adr1", wr_a[1], 2047);
         chk_eq("t3_adr2", wr_a[2], 0);
         chk_eq("t3_adr3", wr_a[3], 1);
      end

      // zero-length job
      run_job(0, 5, 64'h0, 4, -1, -1);
      chk_eq("t4_done", done_c, 1);
      chk_eq("t4_nwr", wr_c.size(), 0);
      chk_eq("t4_npop", pop_c.size(), 0);

      // start while busy must not disturb the running job
      run_job(4, 100, 64'h0, 12, 3, -1);
      chk_eq("t5_nwr", wr_c.size(), 4);
      if (wr_c.size() == 4) begin
         chk_eq("t5_adr0", wr_a[0], 100);
         chk_eq("t5_adr3", wr_a[3], 103);
      end
      chk_eq("t5_done", done_c, 9);
      repeat (3) @(negedge clk);
      chk_eq("t5_idle_busy", busy, 0);

      // reset after the second write of an 8-vector job, then a clean job
      run_job(8, 20, 64'h0, 20, -1, 4);
      chk_eq("t6_nwr_before_rst", wr_c.size(), 2);
      run_job(2, 7, 64'h0, 8, -1, -1);
      chk_eq("t6_nwr", wr_c.size(), 2);
      if (wr_c.size() == 2) begin
         chk_eq("t6_adr0", wr_a[0], 7);
         chk_eq("t6_adr1", wr_a[1], 8);
      end
      chk_eq("t6_done", done_c, 5);

      // lane clamp vector: -5, 7, -32768, 0 (twice)
      data[0] = {2{16'h0000, 16'h8000, 16'h0007, 16'hFFFB}};
`ifdef OFIFO_DRAIN_RELU_EN
      relu_exp = {2{16'h0000, 16'h0000, 16'h0007, 16'h0000}};
`else
      relu_exp = {2{16'h0000, 16'h8000, 16'h0007, 16'hFFFB}};
`endif
      run_job(1, 300, 64'h0, 6, -1, -1);
      chk_eq("t7_nwr", wr_c.size(), 1);
      if (wr_c.size() == 1) begin
         chk_eq("t7_adr", wr_a[0], 300);
         chk_eq("t7_dat", wr_d[0], relu_exp);
      end
      chk_eq("t7_done", done_c, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
